unidade_controle: RTL and testbench

Multicycle control unit for the 16-bit processor datapath (R0–R7, A, G, add/sub ALU, shared bus). It steps through T0–T3 per instruction, decodes the instruction register, and drives every register-load strobe, bus-source select and ALU-mode line the datapath needs. It sits beside the datapath inside the processor top level and is the only driver of the datapath control inputs.

---
 rtl/unidade_controle_if.sv | 27 ++
 rtl/unidade_controle.sv | 142 ++++++++++++++
 tb/tb_unidade_controle.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_if.sv
// rtl/unidade_controle_if.sv - control bus between unidade_controle and the datapath
interface unidade_controle_if;
    logic        Run;
    logic [15:0] IR;
    logic        Gnz;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic        AddSub;
    logic        Done;
    logic [1:0]  Tstep;

    // master is the controller side: it drives every datapath strobe
    modport master (
        input  Run, IR, Gnz,
        output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep
    );

    modport slave (
        output Run, IR, Gnz,
        input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep
    );
endinterface

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle T0-T3 control unit for the 16-bit R0-R7/A/G datapath
module unidade_controle (
    input  logic              Clock,
    input  logic              Resetn,
    unidade_controle_if.master bus
);
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    step_t       r_step;
    step_t       w_step_next;

    logic [2:0]  w_op;
    logic [2:0]  w_x;
    logic [2:0]  w_y;
    logic [7:0]  w_x_hot;
    logic [7:0]  w_y_hot;
    logic        w_is_arith;

    logic        w_irin;
    logic [7:0]  w_rin;
    logic [7:0]  w_rout;
    logic        w_ain;
    logic        w_gin;
    logic        w_gout;
    logic        w_dinout;
    logic        w_addsub;
    logic        w_done;
    logic [1:0]  w_tstep;

    assign w_op       = bus.IR[15:13];
    assign w_x        = bus.IR[12:10];
    assign w_y        = bus.IR[9:7];
    assign w_x_hot    = 8'b0000_0001 << w_x;
    assign w_y_hot    = 8'b0000_0001 << w_y;
    assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_next;
        end
    end

    // Outputs stay zero while Resetn is low so no write strobe escapes the reset cycle.
    always_comb begin
        w_step_next = T0;
        w_irin      = 1'b0;
        w_rin       = 8'h00;
        w_rout      = 8'h00;
        w_ain       = 1'b0;
        w_gin       = 1'b0;
        w_gout      = 1'b0;
        w_dinout    = 1'b0;
        w_addsub    = 1'b0;
        w_done      = 1'b0;
        w_tstep     = 2'd0;

        if (Resetn) begin
            case (r_step)
                T0: begin
                    w_tstep     = 2'd0;
                    w_irin      = bus.Run;
                    w_step_next = bus.Run ? T1 : T0;
                end
                T1: begin
                    w_tstep = 2'd1;
                    case (w_op)
                        OP_MV: begin
                            w_rout = w_y_hot;
                            w_rin  = w_x_hot;
                            w_done = 1'b1;
                        end
                        OP_MVI: begin
                            w_dinout = 1'b1;
                            w_rin    = w_x_hot;
                            w_done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            w_rout      = w_x_hot;
                            w_ain       = 1'b1;
                            w_step_next = T2;
                        end
                        OP_MVNZ: begin
                            w_done = 1'b1;
                            if (bus.Gnz) begin
                                w_rout = w_y_hot;
                                w_rin  = w_x_hot;
                            end
                        end
                        default: begin
                            w_done = 1'b1;
                        end
                    endcase
                end
                // T2/T3 with a non-arithmetic opcode means corrupted state: go quiet and refetch.
                T2: begin
                    if (w_is_arith) begin
                        w_tstep     = 2'd2;
                        w_rout      = w_y_hot;
                        w_gin       = 1'b1;
                        w_addsub    = w_op[0];
                        w_step_next = T3;
                    end
                end
                T3: begin
                    if (w_is_arith) begin
                        w_tstep = 2'd3;
                        w_gout  = 1'b1;
                        w_rin   = w_x_hot;
                        w_done  = 1'b1;
                    end
                end
                default: begin
                    w_step_next = T0;
                end
            endcase
        end
    end

    assign bus.IRin   = w_irin;
    assign bus.Rin    = w_rin;
    assign bus.Rout   = w_rout;
    assign bus.Ain    = w_ain;
    assign bus.Gin    = w_gin;
    assign bus.Gout   = w_gout;
    assign bus.DINout = w_dinout;
    assign bus.AddSub = w_addsub;
    assign bus.Done   = w_done;
    assign bus.Tstep  = w_tstep;
endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - randomized self-checking bench for unidade_controle
module tb_unidade_controle;
    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       done;
        logic [1:0] tstep;
    } ctl_t;

    logic Clock = 1'b0;
    logic Resetn;

    unidade_controle_if ctl ();

    unidade_controle dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (ctl)
    );

    always #5 Clock = ~Clock;

    ctl_t sched[$];
    ctl_t last;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic ctl_t blank(input logic [1:0] t);
        ctl_t c;
        c = '0;
        c.tstep = t;
        return c;
    endfunction

    // Expand one instruction into the list of cycles that follow its fetch.
    task automatic plan(input logic [15:0] ir, input logic gnz);
        logic [2:0] op;
        logic [7:0] xh;
        logic [7:0] yh;
        ctl_t c;
        op = ir[15:13];
        xh = 8'h01 << ir[12:10];
        yh = 8'h01 << ir[9:7];
        case (op)
            3'd0: begin
                c = blank(2'd1); c.rout = yh; c.rin = xh; c.done = 1'b1; sched.push_back(c);
            end
            3'd1: begin
                c = blank(2'd1); c.dinout = 1'b1; c.rin = xh; c.done = 1'b1; sched.push_back(c);
            end
            3'd2, 3'd3: begin
                c = blank(2'd1); c.rout = xh; c.ain = 1'b1; sched.push_back(c);
                c = blank(2'd2); c.rout = yh; c.gin = 1'b1; c.addsub = (op == 3'd3); sched.push_back(c);
                c = blank(2'd3); c.gout = 1'b1; c.rin = xh; c.done = 1'b1; sched.push_back(c);
            end
            3'd4: begin
                c = blank(2'd1); c.done = 1'b1;
                if (gnz) begin
                    c.rout = yh;
                    c.rin  = xh;
                end
                sched.push_back(c);
            end
            default: begin
                c = blank(2'd1); c.done = 1'b1; sched.push_back(c);
            end
        endcase
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.irin   = ctl.IRin;
        c.rin    = ctl.Rin;
        c.rout   = ctl.Rout;
        c.ain    = ctl.Ain;
        c.gin    = ctl.Gin;
        c.gout   = ctl.Gout;
        c.dinout = ctl.DINout;
        c.addsub = ctl.AddSub;
        c.done   = ctl.Done;
        c.tstep  = ctl.Tstep;
        return c;
    endfunction

    task automatic cycle(input logic rstn, input logic run, input logic [15:0] ir,
                         input logic gnz, input string tag);
        ctl_t exp;
        ctl_t got;
        int   srcs;
        Resetn  = rstn;
        ctl.Run = run;
        ctl.IR  = ir;
        ctl.Gnz = gnz;
        if (!rstn) begin
            exp = '0;
            sched.delete();
        end else if (sched.size() == 0) begin
            exp = blank(2'd0);
            exp.irin = run;
            if (run) plan(ir, gnz);
        end else begin
            exp = sched.pop_front();
        end
        @(negedge Clock);
        got = observe();
        check_eq(tag, 32'(got), 32'(exp));
        srcs = $countones(got.rout) + int'(got.gout) + int'(got.dinout);
        check_eq({tag, "_bus"}, 32'(srcs <= 1), 32'd1);
        last = got;
        @(posedge Clock);
        #1;
    endtask

    int         n_done;
    logic       r_rstn;
    logic [15:0] cur_ir;
    logic       cur_gnz;

    initial begin
        Resetn  = 1'b0;
        ctl.Run = 1'b0;
        ctl.IR  = 16'h0000;
        ctl.Gnz = 1'b0;

        cycle(1'b0, 1'b1, 16'h2000, 1'b0, "rst0");
        check_eq("rst0_irin", 32'(last.irin), 32'd0);
        cycle(1'b0, 1'b1, 16'h2000, 1'b0, "rst1");
        check_eq("rst1_tstep", 32'(last.tstep), 32'd0);
        cycle(1'b1, 1'b1, 16'h2000, 1'b0, "fetch_after_rst");
        check_eq("irin_after_rst", 32'(last.irin), 32'd1);
        cycle(1'b1, 1'b0, 16'h2000, 1'b0, "mvi_r0_t1");

        cycle(1'b1, 1'b1, 16'h3400, 1'b0, "mvi_t0");
        cycle(1'b1, 1'b0, 16'h3400, 1'b0, "mvi_t1");
        check_eq("mvi_rin", 32'(last.rin), 32'h20);
        check_eq("mvi_din", 32'(last.dinout), 32'd1);
        cycle(1'b1, 1'b1, 16'h0680, 1'b0, "mv_t0");
        cycle(1'b1, 1'b1, 16'h0680, 1'b0, "mv_t1");
        check_eq("mv_rout", 32'(last.rout), 32'h20);
        check_eq("mv_rin", 32'(last.rin), 32'h02);

        cycle(1'b1, 1'b1, 16'h6B00, 1'b0, "sub_t0");
        cycle(1'b1, 1'b0, 16'h6B00, 1'b0, "sub_t1");
        check_eq("sub_t1_rout", 32'(last.rout), 32'h04);
        cycle(1'b1, 1'b1, 16'h6B00, 1'b0, "sub_t2");
        check_eq("sub_t2_rout", 32'(last.rout), 32'h40);
        check_eq("sub_addsub", 32'(last.addsub), 32'd1);
        cycle(1'b1, 1'b0, 16'h6B00, 1'b0, "sub_t3");
        check_eq("sub_t3_rin", 32'(last.rin), 32'h04);
        cycle(1'b1, 1'b0, 16'h6B00, 1'b0, "sub_after");
        check_eq("sub_after_tstep", 32'(last.tstep), 32'd0);

        cycle(1'b1, 1'b1, 16'h8380, 1'b0, "mvnz0_t0");
        cycle(1'b1, 1'b0, 16'h8380, 1'b0, "mvnz0_t1");
        check_eq("mvnz0_rin", 32'(last.rin), 32'h00);
        check_eq("mvnz0_done", 32'(last.done), 32'd1);
        cycle(1'b1, 1'b1, 16'h8380, 1'b1, "mvnz1_t0");
        cycle(1'b1, 1'b0, 16'h8380, 1'b1, "mvnz1_t1");
        check_eq("mvnz1_rout", 32'(last.rout), 32'h80);
        check_eq("mvnz1_rin", 32'(last.rin), 32'h01);

        cycle(1'b1, 1'b1, 16'h4480, 1'b0, "add_t0");
        cycle(1'b1, 1'b0, 16'h4480, 1'b0, "add_t1");
        cycle(1'b0, 1'b0, 16'h4480, 1'b0, "add_t2_rst");
        check_eq("add_rst_gin", 32'(last.gin), 32'd0);
        cycle(1'b1, 1'b0, 16'h4480, 1'b0, "add_abandon");
        check_eq("add_abandon_tstep", 32'(last.tstep), 32'd0);
        check_eq("add_abandon_rin", 32'(last.rin), 32'h00);

        cycle(1'b1, 1'b1, 16'hE000, 1'b1, "rsv_t0");
        cycle(1'b1, 1'b1, 16'hE000, 1'b1, "rsv_t1");
        check_eq("rsv_done", 32'(last.done), 32'd1);

        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 16'h0680 + 16'(i / 2) * 16'h0400, 1'b0, "b2b");
            n_done += int'(last.done);
        end
        check_eq("b2b_done", 32'(n_done), 32'd3);

        cur_ir  = 16'h0000;
        cur_gnz = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r_rstn = ($urandom_range(0, 29) != 0);
            if (sched.size() == 0) begin
                cur_ir  = 16'($urandom);
                cur_gnz = 1'($urandom_range(0, 1));
            end
            cycle(r_rstn, 1'($urandom_range(0, 1)), cur_ir, cur_gnz, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
